ifu: RTL and testbench

Instruction fetch unit for the single-cycle-style RV32I core. It holds the architectural PC and fetches one instruction per step from instruction memory over a valid/ready request and valid-only response handshake. It presents the instruction word to the control signal generator (`op`=`inst[6:0]`, `func3`=`inst[14:12]`, `func7`=`inst[31:25]`). Once execute signals completion, it computes the next PC from the generator's `Branch` code and the ALU flags.

---
 rtl/ifu.sv | 111 +++++++++++
 tb/tb_ifu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ifu                                                          |
// | Brief   : RV32I instruction fetch unit: PC, imem handshake, next-PC.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic [2:0]  branch,
    input  logic        zero,
    input  logic        less,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        misalign
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_misalign;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_imm;
    logic [31:0] w_npc;
    logic        w_npc_ok;
    logic        w_retire;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_imm   = r_pc + imm;
    assign w_retire   = (r_state == S_EXEC) && exec_done;
    assign w_npc_ok   = (w_npc[1:0] == 2'b00);

    always_comb begin
        w_npc = w_pc_plus4;
        case (branch)
            3'b001:  w_npc = w_pc_imm;
            3'b010:  w_npc = (rs1_data + imm) & ~32'h1;
            3'b100:  w_npc = zero  ? w_pc_imm : w_pc_plus4;
            3'b101:  w_npc = !zero ? w_pc_imm : w_pc_plus4;
            3'b110:  w_npc = less  ? w_pc_imm : w_pc_plus4;
            3'b111:  w_npc = !less ? w_pc_imm : w_pc_plus4;
            default: w_npc = w_pc_plus4;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (exec_done) w_state_nxt = w_npc_ok ? S_FETCH : S_HALT;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_inst     <= c_NOP;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Responses only count while a request is outstanding.
            if ((r_state == S_WAIT) && imem_resp_valid) r_inst <= imem_resp_data;
            if (w_retire && w_npc_ok)  r_pc       <= w_npc;
            if (w_retire && !w_npc_ok) r_misalign <= 1'b1;
        end
    end

    assign imem_req_addr = r_pc;
    assign pc            = r_pc;
    assign inst          = r_inst;
    assign misalign      = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_ifu                                                       |
// | Brief   : Self-checking bench for ifu: directed vectors and sequences. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_ifu;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        exec_done = 1'b0;
    logic [2:0]  branch = 3'b000;
    logic        zero = 1'b0;
    logic        less = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(c_RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .pc              (pc),
        .exec_done       (exec_done),
        .branch          (branch),
        .zero            (zero),
        .less            (less),
        .imm             (imm),
        .rs1_data        (rs1_data),
        .misalign        (misalign)
    );

    typedef struct {
        logic [31:0] start;
        logic [2:0]  br;
        logic        z;
        logic        l;
        logic [31:0] imm_v;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Leaves the bench at a negedge where the DUT is in FETCH.
    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_timeout: got no request expected imem_req_valid=1");
        end
    endtask

    // One zero-wait-state instruction; ends at the negedge after exec_done.
    task automatic run_inst(input logic [2:0] br, input logic z, input logic l,
                            input logic [31:0] imm_v, input logic [31:0] rs1,
                            input logic [31:0] data);
        bit ok;
        wait_fetch(ok);
        if (!ok) return;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        check1("wait_req_valid", imem_req_valid, 1'b0);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check1("exec_inst_valid", inst_valid, 1'b1);
        check32("exec_inst", inst, data);
        exec_done = 1'b1;
        branch    = br;
        zero      = z;
        less      = l;
        imm       = imm_v;
        rs1_data  = rs1;
        @(negedge clk);
        exec_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] addr0;

        vecs[0]  = '{32'h8000_0100, 3'b100, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h8000_00F0};
        vecs[1]  = '{32'h8000_0100, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h8000_0104};
        vecs[2]  = '{32'h8000_0100, 3'b111, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h8000_0104};
        vecs[3]  = '{32'h8000_0100, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h8000_00F0};
        vecs[4]  = '{32'h8000_0100, 3'b101, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h8000_0104};
        vecs[5]  = '{32'h8000_0100, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h8000_00F0};
        vecs[6]  = '{32'h8000_0100, 3'b111, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h8000_00F0};
        vecs[7]  = '{32'h8000_0000, 3'b001, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h8000_0020};
        vecs[8]  = '{32'h8000_0000, 3'b010, 1'b0, 1'b0, 32'h0000_0005, 32'h8000_1000, 32'h8000_1004};
        vecs[9]  = '{32'h8000_0200, 3'b011, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 32'h8000_0204};
        vecs[10] = '{32'hFFFF_FFFC, 3'b000, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000};
        vecs[11] = '{32'h0000_0010, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h0, 32'hFFFF_FFF0};

        // Reset state
        repeat (2) @(negedge clk);
        check32("rst_pc", pc, c_RESET_PC);
        check32("rst_inst", inst, c_NOP);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_misalign", misalign, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check1("first_req", imem_req_valid, 1'b1);
        check32("first_addr", imem_req_addr, c_RESET_PC);

        // Sequential fetch with 3-cycle cadence
        for (int i = 0; i < 3; i++) begin
            check32("seq_addr", imem_req_addr, c_RESET_PC + 32'(4 * i));
            run_inst(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0113 + 32'(i));
            check1("seq_cadence_req", imem_req_valid, 1'b1);
            check1("seq_inst_drop", inst_valid, 1'b0);
        end

        // Backpressure, response in acceptance cycle, delayed response
        addr0 = imem_req_addr;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("bp_req_valid", imem_req_valid, 1'b1);
            check32("bp_addr", imem_req_addr, addr0);
        end
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0BAD;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check1("lat_req_valid", imem_req_valid, 1'b0);
            check1("lat_inst_valid", inst_valid, 1'b0);
            @(negedge clk);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0040_0093;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check1("lat_inst_valid_set", inst_valid, 1'b1);
        check32("lat_inst", inst, 32'h0040_0093);
        exec_done = 1'b1;
        branch    = 3'b000;
        @(negedge clk);
        exec_done = 1'b0;
        check32("lat_next_pc", pc, addr0 + 32'd4);

        // Next-PC vector table
        for (int i = 0; i < 12; i++) begin
            run_inst(3'b010, 1'b0, 1'b0, 32'h0, vecs[i].start, c_NOP);
            check32("vec_start_pc", pc, vecs[i].start);
            run_inst(vecs[i].br, vecs[i].z, vecs[i].l, vecs[i].imm_v, vecs[i].rs1, 32'h0000_0063);
            check32($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check1("vec_misalign", misalign, 1'b0);
        end

        // exec_done in FETCH is ignored
        wait_fetch(ok);
        addr0     = pc;
        exec_done = 1'b1;
        branch    = 3'b001;
        imm       = 32'h0000_0100;
        @(negedge clk);
        exec_done = 1'b0;
        check32("fetch_exec_done_pc", pc, addr0);
        check1("fetch_exec_done_req", imem_req_valid, 1'b1);

        // Reset in WAIT, stale response in IDLE and FETCH
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check32("async_rst_pc", pc, c_RESET_PC);
        check1("async_rst_req", imem_req_valid, 1'b0);
        @(negedge clk);
        rst_n           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        check32("stale_idle_inst", inst, c_NOP);
        check1("stale_inst_valid", inst_valid, 1'b0);
        check1("fresh_req", imem_req_valid, 1'b1);
        check32("fresh_addr", imem_req_addr, c_RESET_PC);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check32("stale_fetch_inst", inst, c_NOP);
        check1("stale_fetch_req", imem_req_valid, 1'b1);

        // jalr to a misaligned target halts
        run_inst(3'b010, 1'b0, 1'b0, 32'h0, 32'h8000_1003, 32'h0000_0067);
        check1("halt_misalign", misalign, 1'b1);
        check32("halt_pc", pc, c_RESET_PC);
        check1("halt_inst_valid", inst_valid, 1'b0);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check1("halt_no_req", imem_req_valid, 1'b0);
            check1("halt_sticky", misalign, 1'b1);
            @(negedge clk);
        end
        imem_req_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
